rsa_modexp_seq: RTL and testbench
=================================

// Module: rsa_modexp_seq
// PURPOSE
//  Sequential, parametrised RSA modular-exponentiation engine: result = base^exp mod n.
//  Successor to the 8-bit combinational decrypt block: WIDTH-generic, clocked, start/done handshake.
//  Serves both encrypt (exp=e) and decrypt (exp=d); the caller selects the exponent.
//  Built from two interleaved shift-add modular multipliers running in parallel; no divider.
// PARAMETERS
//  WIDTH  8  operand/result width in bits (>=4)
// PORTS
//  clk     in   1      rising-edge clock
//  rst_n   in   1      asynchronous active-low reset
//  start   in   1      request; sampled only in IDLE
//  base    in   WIDTH  message/ciphertext; may be >= n
//  exp     in   WIDTH  exponent (e or d)
//  n       in   WIDTH  modulus
//  busy    out  1      high from the cycle after start is accepted until done
//  done    out  1      one-cycle pulse; result/err valid from this cycle
//  result  out  WIDTH  base^exp mod n; held until the next accepted start
//  err     out  1      set with done when n<2; held like result
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, err=0; internal regs cleared.
//  Reset mid-operation aborts the run; no done is generated.
//  IDLE: start=1 at edge T captures base/exp/n. Operands are ignored after capture.
//   n<2 -> state DONE at T, done=1 and err=1 in cycle T+1, result=0.
//   else -> REDUCE; err cleared; busy=1 from T+1.
//  start while busy or in DONE is ignored (no queueing).
//  modmul(a,b), a<n: acc=0; for i=WIDTH-1..0: acc=2*acc; if acc>=n acc-=n;
//   if b[i] { acc+=a; if acc>=n acc-=n; }. One bit per cycle, WIDTH cycles.
//   Internal acc is WIDTH+1 bits (2*acc < 2n); no overflow for any n<2^WIDTH.
//  REDUCE (WIDTH cycles): b_reg = modmul(1, base) = base mod n; r_reg = 1.
//  STEP (WIDTH rounds x WIDTH cycles, right-to-left over exp bits j=0..WIDTH-1):
//   both multipliers run concurrently each round:
//   r_reg <= exp[j] ? modmul(r_reg,b_reg) : r_reg; b_reg <= modmul(b_reg,b_reg).
//   All rounds run even when the remaining exp bits are zero (fixed, data-independent latency).
//  DONE: result <= r_reg; done=1 for exactly one cycle; busy=0; -> IDLE.
//  Latency: start at edge T -> done high in cycle T + WIDTH + WIDTH*WIDTH + 1 (73 for WIDTH=8).
//  Back-to-back: a new start is accepted in the cycle after done (IDLE).
//  Edge results: exp=0 -> 1; base mod n = 0 with exp!=0 -> 0; n = 2^WIDTH-1 is legal.
//  Inputs are unsigned; result is always < n when err=0.
// TESTING
//  1. WIDTH=8, base=29, exp=3, n=33 -> done at T+73, result=2, err=0, busy high T+1..T+72.
//  2. WIDTH=8, base=2, exp=7, n=33 (encrypt) -> result=29; round-trip with test 1 passes.
//  3. base=40, exp=1, n=33 -> result=7 (reduction); base=5, exp=0, n=33 -> result=1.
//  4. n=1 and n=0 -> done at T+1, err=1, result=0; next start with n=33 clears err.
//  5. Pulse start again at T+10 during test 1 -> ignored, one done, result=2.
//     Drop rst_n at T+30 -> outputs 0 immediately, no done; restart -> result=2.
//  6. WIDTH=16, base=65, exp=17, n=3233 -> result=2790 at T+273.
//     Plus 1000 random WIDTH=8 vectors checked against a bench-side behavioural reference model.

Source files
------------

// File: rtl/rsa_modexp_seq.sv
// Sequential modular exponentiation: result = base^exp mod n, right-to-left binary method
// built on two shift-add modular multipliers that run side by side, one bit per cycle.
module rsa_modexp_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] exp,
  input  logic [WIDTH-1:0] n,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, REDUCE, STEP, DONE} state_t;

  // One interleaved iteration: acc = 2*acc mod m, then (+a) mod m. acc,a < m keeps
  // every intermediate below 2m, so WIDTH+1 bits never overflow.
  function automatic logic [WIDTH-1:0] mm_step(input logic [WIDTH-1:0] acc,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] m,
                                               input logic             bit_i);
    logic [WIDTH:0] t;
    t = {acc, 1'b0};
    if (t >= {1'b0, m}) t = t - {1'b0, m};
    if (bit_i) begin
      t = t + {1'b0, a};
      if (t >= {1'b0, m}) t = t - {1'b0, m};
    end
    return t[WIDTH-1:0];
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    bit_q, bit_d;
  logic [CW-1:0]    rnd_q, rnd_d;
  logic [WIDTH-1:0] base_q, base_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] acc_r_q, acc_r_d;
  logic [WIDTH-1:0] acc_b_q, acc_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] acc_r_nxt, acc_b_nxt, mb_a, r_new;
  logic             mb_bit;

  // Multiplier B doubles as the base reducer (a=1, b=base) during REDUCE.
  always_comb begin
    mb_a      = (state_q == REDUCE) ? WIDTH'(1) : b_q;
    mb_bit    = (state_q == REDUCE) ? base_q[bit_q] : b_q[bit_q];
    acc_r_nxt = mm_step(acc_r_q, r_q, n_q, b_q[bit_q]);
    acc_b_nxt = mm_step(acc_b_q, mb_a, n_q, mb_bit);
  end

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    rnd_d    = rnd_q;
    base_d   = base_q;
    exp_d    = exp_q;
    n_d      = n_q;
    b_d      = b_q;
    r_d      = r_q;
    acc_r_d  = acc_r_q;
    acc_b_d  = acc_b_q;
    result_d = result_q;
    err_d    = err_q;
    r_new    = exp_q[rnd_q] ? acc_r_nxt : r_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base;
          exp_d   = exp;
          n_d     = n;
          acc_r_d = '0;
          acc_b_d = '0;
          bit_d   = CW'(WIDTH - 1);
          rnd_d   = '0;
          if (n < WIDTH'(2)) begin
            state_d  = DONE;
            result_d = '0;
            err_d    = 1'b1;
          end else begin
            state_d = REDUCE;
            err_d   = 1'b0;
          end
        end
      end
      REDUCE: begin
        acc_b_d = acc_b_nxt;
        bit_d   = bit_q - 1'b1;
        if (bit_q == '0) begin
          b_d     = acc_b_nxt;
          r_d     = WIDTH'(1);
          acc_b_d = '0;
          bit_d   = CW'(WIDTH - 1);
          state_d = STEP;
        end
      end
      STEP: begin
        acc_r_d = acc_r_nxt;
        acc_b_d = acc_b_nxt;
        bit_d   = bit_q - 1'b1;
        if (bit_q == '0) begin
          r_d     = r_new;
          b_d     = acc_b_nxt;
          acc_r_d = '0;
          acc_b_d = '0;
          bit_d   = CW'(WIDTH - 1);
          rnd_d   = rnd_q + 1'b1;
          // Last round: publish the fresh product so result is valid with done.
          if (rnd_q == CW'(WIDTH - 1)) begin
            state_d  = DONE;
            result_d = r_new;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      rnd_q    <= '0;
      base_q   <= '0;
      exp_q    <= '0;
      n_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      acc_r_q  <= '0;
      acc_b_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      rnd_q    <= rnd_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      n_q      <= n_d;
      b_q      <= b_d;
      r_q      <= r_d;
      acc_r_q  <= acc_r_d;
      acc_b_q  <= acc_b_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign busy   = (state_q == REDUCE) || (state_q == STEP);
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign err    = err_q;

endmodule

// File: tb/tb_rsa_modexp_seq.sv
// Scoreboard bench for rsa_modexp_seq: WIDTH=8 and WIDTH=16 instances, directed vectors
// with hand-derived results plus random 8-bit vectors against a square-and-multiply model.
module tb_rsa_modexp_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start8 = 1'b0, start16 = 1'b0;
  logic [7:0]  base8 = '0, exp8 = '0, n8 = '0;
  logic [15:0] base16 = '0, exp16 = '0, n16 = '0;
  logic        busy8, done8, err8, busy16, done16, err16;
  logic [7:0]  result8;
  logic [15:0] result16;

  rsa_modexp_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .base(base8), .exp(exp8), .n(n8),
    .busy(busy8), .done(done8), .result(result8), .err(err8));

  rsa_modexp_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .base(base16), .exp(exp16), .n(n16),
    .busy(busy16), .done(done16), .result(result16), .err(err16));

  typedef struct {
    logic [15:0] res;
    logic        err;
    longint      t0;
    longint      lat;
  } exp_t;

  exp_t   q8[$], q16[$];
  longint cyc = 0;
  int     n_chk = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  function automatic logic [15:0] mexp(input longint b, input longint e, input longint m);
    longint r, bb;
    if (m < 2) return 16'd0;
    r  = 1;
    bb = b % m;
    for (int i = 0; i < 16; i++) begin
      if ((e >> i) & 1) r = (r * bb) % m;
      bb = (bb * bb) % m;
    end
    return 16'(r);
  endfunction

  // Monitors: pop and compare on every done pulse.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      chk("done8_expected", 64'(q8.size() > 0), 64'd1);
      if (q8.size() > 0) begin
        exp_t e;
        e = q8.pop_front();
        chk("result8", 64'(result8), 64'(e.res));
        chk("err8", 64'(err8), 64'(e.err));
        chk("latency8", 64'(cyc - e.t0), 64'(e.lat));
        chk("busy8_at_done", 64'(busy8), 64'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done16) begin
      chk("done16_expected", 64'(q16.size() > 0), 64'd1);
      if (q16.size() > 0) begin
        exp_t e;
        e = q16.pop_front();
        chk("result16", 64'(result16), 64'(e.res));
        chk("err16", 64'(err16), 64'(e.err));
        chk("latency16", 64'(cyc - e.t0), 64'(e.lat));
      end
    end
  end

  // Issue a start for one cycle; returns at the negedge of the first cycle after capture.
  task automatic start_op(input bit w, input logic [15:0] b, input logic [15:0] e,
                          input logic [15:0] m, input logic [15:0] res, input bit push);
    exp_t x;
    @(negedge clk);
    x.t0  = cyc;
    x.res = res;
    x.err = (m < 2);
    if (w) begin
      base16 = b; exp16 = e; n16 = m; start16 = 1'b1;
      x.lat = (m < 2) ? 1 : 16 + 16 * 16 + 1;
      if (push) q16.push_back(x);
    end else begin
      base8 = b[7:0]; exp8 = e[7:0]; n8 = m[7:0]; start8 = 1'b1;
      x.lat = (m < 2) ? 1 : 8 + 8 * 8 + 1;
      if (push) q8.push_back(x);
    end
    @(negedge clk);
    start8  = 1'b0;
    start16 = 1'b0;
  endtask

  // Wait (bounded) until done is visible; counts busy cycles seen on the way.
  task automatic wait_done(input bit w, output int bc);
    bit seen;
    seen = 0;
    bc   = 0;
    for (int i = 0; i < 400; i++) begin
      if (w ? done16 : done8) begin
        seen = 1;
        break;
      end
      if (w ? busy16 : busy8) bc++;
      @(negedge clk);
    end
    chk(w ? "done16_timeout" : "done8_timeout", 64'(seen), 64'd1);
  endtask

  initial begin
    int bc;
    logic [7:0] rb, re, rm;

    #12;
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_result", 64'(result8), 64'd0);
    chk("rst_err", 64'(err8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Decrypt 29^3 mod 33 = 2, with busy window check.
    start_op(0, 16'd29, 16'd3, 16'd33, 16'd2, 1);
    wait_done(0, bc);
    chk("busy8_cycles", 64'(bc), 64'd72);
    // Encrypt 2^7 mod 33 = 29 (round trip of the above), back-to-back.
    start_op(0, 16'd2, 16'd7, 16'd33, 16'd29, 1);
    wait_done(0, bc);
    start_op(0, 16'd40, 16'd1, 16'd33, 16'd7, 1);
    wait_done(0, bc);
    start_op(0, 16'd5, 16'd0, 16'd33, 16'd1, 1);
    wait_done(0, bc);
    start_op(0, 16'd33, 16'd5, 16'd33, 16'd0, 1);
    wait_done(0, bc);
    start_op(0, 16'd2, 16'd8, 16'd255, 16'd1, 1);
    wait_done(0, bc);
    start_op(0, 16'd254, 16'd255, 16'd255, 16'd254, 1);
    wait_done(0, bc);
    // Degenerate moduli, then a normal run clears err.
    start_op(0, 16'd7, 16'd3, 16'd1, 16'd0, 1);
    wait_done(0, bc);
    start_op(0, 16'd7, 16'd3, 16'd0, 16'd0, 1);
    wait_done(0, bc);
    start_op(0, 16'd29, 16'd3, 16'd33, 16'd2, 1);
    wait_done(0, bc);

    // A start pulse while busy must be ignored.
    start_op(0, 16'd29, 16'd3, 16'd33, 16'd2, 1);
    repeat (9) @(negedge clk);
    base8 = 8'd5; exp8 = 8'd0; n8 = 8'd1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done(0, bc);
    repeat (5) @(negedge clk);

    // Reset mid-run aborts without done.
    start_op(0, 16'd29, 16'd3, 16'd33, 16'd0, 0);
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 64'(busy8), 64'd0);
    chk("abort_done", 64'(done8), 64'd0);
    chk("abort_result", 64'(result8), 64'd0);
    chk("abort_err", 64'(err8), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    start_op(0, 16'd29, 16'd3, 16'd33, 16'd2, 1);
    wait_done(0, bc);

    // 16-bit textbook RSA vector.
    start_op(1, 16'd65, 16'd17, 16'd3233, 16'd2790, 1);
    wait_done(1, bc);
    chk("busy16_cycles", 64'(bc), 64'd272);

    for (int i = 0; i < 1000; i++) begin
      rb = 8'($urandom_range(0, 255));
      re = 8'($urandom_range(0, 255));
      if (i % 100 == 7)       rm = 8'd0;
      else if (i % 100 == 57) rm = 8'd1;
      else if (i % 50 == 3)   rm = 8'd255;
      else                    rm = 8'($urandom_range(2, 255));
      start_op(0, 16'(rb), 16'(re), 16'(rm), mexp(64'(rb), 64'(re), 64'(rm)), 1);
      wait_done(0, bc);
    end

    repeat (3) @(negedge clk);
    chk("q8_drained", 64'(q8.size()), 64'd0);
    chk("q16_drained", 64'(q16.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
